// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment display blocks.
package seg_pkg;

    localparam int unsigned SEG_W      = 7;
    localparam int unsigned NUM_DIGITS = 3;
    localparam int unsigned DIG_W      = 2;

    localparam logic [SEG_W-1:0]      SEG_BLANK = 7'b1111111;
    localparam logic [NUM_DIGITS-1:0] AN_OFF    = 3'b111;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_SHOW  = 1'b1
    } scan_state_e;

    // Active-low one-cold anode enable for digit d.
    function automatic logic [NUM_DIGITS-1:0] an_sel(input logic [DIG_W-1:0] d);
        return ~(NUM_DIGITS'(1) << d);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running tick generator: one-cycle tick every PRESCALE enabled cycles.
module tick_prescaler #(
    parameter int unsigned PRESCALE = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q;
        if (!en || (cnt_q == CNT_MAX)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexes three static segment patterns onto a shared bus with
// per-digit anode enables, blanking dead-time and a frame-done pulse.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int unsigned PRESCALE    = 50000,
    parameter int unsigned ON_TICKS    = 4,
    parameter int unsigned BLANK_TICKS = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [0:SEG_W-1]      led0,
    input  logic [0:SEG_W-1]      led1,
    input  logic [0:SEG_W-1]      led2,
    output logic [0:SEG_W-1]      seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  frame_done
);

    localparam int unsigned SLOT_MAX = (ON_TICKS > BLANK_TICKS) ? ON_TICKS : BLANK_TICKS;
    localparam int unsigned SLOT_W   = $clog2(SLOT_MAX + 1);
    localparam logic [SLOT_W-1:0] BLANK_LAST = SLOT_W'(BLANK_TICKS - 1);
    localparam logic [SLOT_W-1:0] ON_LAST    = SLOT_W'(ON_TICKS - 1);
    localparam logic [DIG_W-1:0]  DIG_LAST   = DIG_W'(NUM_DIGITS - 1);

    scan_state_e           state_q, state_d;
    logic [DIG_W-1:0]      digit_q, digit_d;
    logic [SLOT_W-1:0]     slot_q, slot_d;
    logic [0:SEG_W-1]      seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_done_q, frame_done_d;
    logic [0:SEG_W-1]      led_sel_c;
    logic                  tick;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .tick (tick)
    );

    always_comb begin
        case (digit_q)
            DIG_W'(0): led_sel_c = led0;
            DIG_W'(1): led_sel_c = led1;
            default:   led_sel_c = led2;
        endcase
    end

    // seg_q doubles as the snapshot register: loaded only on BLANK->SHOW.
    always_comb begin
        state_d      = state_q;
        digit_d      = digit_q;
        slot_d       = slot_q;
        seg_d        = seg_q;
        an_d         = an_q;
        frame_done_d = 1'b0;
        if (!en) begin
            state_d = S_BLANK;
            digit_d = '0;
            slot_d  = '0;
            seg_d   = SEG_BLANK;
            an_d    = AN_OFF;
        end else if (tick) begin
            case (state_q)
                S_BLANK: begin
                    if (slot_q == BLANK_LAST) begin
                        state_d = S_SHOW;
                        slot_d  = '0;
                        seg_d   = led_sel_c;
                        an_d    = an_sel(digit_q);
                    end else begin
                        slot_d = slot_q + SLOT_W'(1);
                    end
                end
                S_SHOW: begin
                    if (slot_q == ON_LAST) begin
                        state_d = S_BLANK;
                        slot_d  = '0;
                        seg_d   = SEG_BLANK;
                        an_d    = AN_OFF;
                        if (digit_q == DIG_LAST) begin
                            digit_d      = '0;
                            frame_done_d = 1'b1;
                        end else begin
                            digit_d = digit_q + DIG_W'(1);
                        end
                    end else begin
                        slot_d = slot_q + SLOT_W'(1);
                    end
                end
                default: begin
                    state_d = S_BLANK;
                    slot_d  = '0;
                    seg_d   = SEG_BLANK;
                    an_d    = AN_OFF;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_BLANK;
            digit_q      <= '0;
            slot_q       <= '0;
            seg_q        <= SEG_BLANK;
            an_q         <= AN_OFF;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            digit_q      <= digit_d;
            slot_q       <= slot_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule
